// File: rtl/plm_port_arbiter.sv
// Round-robin arbiter sharing one PLM bank port among NCONSUMERS requesters, with read-tag return path.
// Optional per-consumer grant/stall statistics are built only when PLM_PORT_ARB_STATS_EN is defined.
module plm_port_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4,
  parameter int PLM_LATENCY = 1,
  parameter int STATS_WIDTH = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [NCONSUMERS-1:0]                     req_valid_i,
  input  logic [NCONSUMERS-1:0]                     req_wr_i,
  input  logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]    req_value_i,
  output logic [NCONSUMERS-1:0]                     req_ready_o,
  output logic [ADDR_WIDTH+VALUE_WIDTH:0]           plm_input_o,
  input  logic [VALUE_WIDTH-1:0]                    plm_output_i,
  output logic [NCONSUMERS-1:0]                     rsp_valid_o,
  output logic [VALUE_WIDTH-1:0]                    rsp_data_o,
  output logic [NCONSUMERS-1:0][STATS_WIDTH-1:0]    grant_count_o,
  output logic [NCONSUMERS-1:0][STATS_WIDTH-1:0]    stall_count_o
);

  localparam int IDW = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  if (PLM_LATENCY < 1 || PLM_LATENCY > 4) begin : g_bad_latency
    $error("plm_port_arbiter: PLM_LATENCY must be in 1..4");
  end
  if (NCONSUMERS < 2) begin : g_bad_ncons
    $error("plm_port_arbiter: NCONSUMERS must be at least 2");
  end

  logic [IDW-1:0]                    pivot_q, pivot_d;
  logic                              grant_any;
  logic [IDW-1:0]                    grant_id;
  logic [IDW:0]                      idx_sum;
  logic [PLM_LATENCY-1:0]            tag_v_q;
  logic [PLM_LATENCY-1:0][IDW-1:0]   tag_id_q;

  // Scan pivot, pivot+1, ... wrapping at NCONSUMERS; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx_sum   = '0;
    for (int k = 0; k < NCONSUMERS; k++) begin
      idx_sum = {1'b0, pivot_q} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NCONSUMERS)) begin
        idx_sum = idx_sum - (IDW+1)'(NCONSUMERS);
      end
      if (!grant_any && req_valid_i[idx_sum[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx_sum[IDW-1:0];
      end
    end
    if (reset_i) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready_o = '0;
    plm_input_o = '0;
    pivot_d     = pivot_q;
    if (grant_any) begin
      req_ready_o[grant_id] = 1'b1;
      plm_input_o = {req_addr_i[grant_id], req_value_i[grant_id], req_wr_i[grant_id]};
      pivot_d     = (grant_id == IDW'(NCONSUMERS-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pivot_q  <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      pivot_q <= pivot_d;
      for (int s = PLM_LATENCY-1; s > 0; s--) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      tag_v_q[0]  <= grant_any && !req_wr_i[grant_id];
      tag_id_q[0] <= grant_id;
    end
  end

  // Responses from reads issued before a reset are suppressed while reset is high.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (tag_v_q[PLM_LATENCY-1] && !reset_i) begin
      rsp_valid_o[tag_id_q[PLM_LATENCY-1]] = 1'b1;
      rsp_data_o = plm_output_i;
    end
  end

`ifdef PLM_PORT_ARB_STATS_EN
  logic [NCONSUMERS-1:0][STATS_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
  logic [NCONSUMERS-1:0][STATS_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: hold at all-ones until the next reset.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NCONSUMERS; i++) begin
      if (req_ready_o[i] && !(&grant_cnt_q[i])) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
      end
      if (req_valid_i[i] && !req_ready_o[i] && !(&stall_cnt_q[i])) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_count_o = grant_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  assign grant_count_o = '0;
  assign stall_count_o = '0;
`endif

endmodule
